// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: one-clock tick every DIV clocks, forced back to zero by restart_i.
module baud_gen #(
    parameter int unsigned DIV = 43
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one word per frame from a first-word-fall-through FIFO and sends it as 8N1 UART.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int          DATA_BITS = 3,
    parameter int unsigned CLK_HZ    = 5_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int          ASCII_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

    tx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        rd_en_q, rd_en_d;
    logic        busy_q;
    logic        tick;
    logic        restart;
    logic [7:0]  word_ext;
    logic [7:0]  enc;

    baud_gen #(.DIV(DIV)) u_baud (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_comb begin
        word_ext = 8'(fifo_data);
        enc      = (ASCII_EN != 0) ? word_ext + 8'h30 : word_ext;
    end

    // tx_q follows the current state one clock later, so the pop cycle precedes the start bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        rd_en_d = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    shift_d = enc;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign restart = (state_q == IDLE) || (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = (state_q != IDLE) || busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FWFT FIFO models, waveform capture and frame decoding.
module tb_fifo_uart_tx;

    localparam int DIV  = 43;
    localparam int NREC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fifo_data, raw_data;
    logic       fifo_empty, raw_empty;
    logic       fifo_rd_en, tx, busy;
    logic       raw_rd_en, raw_tx, raw_busy;

    logic [2:0] mem [0:15];
    logic [2:0] raw_mem [0:15];
    int         wptr = 0, rptr = 0, raw_wptr = 0, raw_rptr = 0;

    assign fifo_empty = (wptr == rptr);
    assign fifo_data  = mem[rptr[3:0]];
    assign raw_empty  = (raw_wptr == raw_rptr);
    assign raw_data   = raw_mem[raw_rptr[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) rptr <= rptr + 1;
        if (raw_rd_en && !raw_empty) raw_rptr <= raw_rptr + 1;
    end

    fifo_uart_tx #(.DATA_BITS(3), .CLK_HZ(5_000_000), .BAUD(115200), .ASCII_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    fifo_uart_tx #(.DATA_BITS(3), .CLK_HZ(5_000_000), .BAUD(115200), .ASCII_EN(0)) dut_raw (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (raw_data),
        .fifo_empty (raw_empty),
        .fifo_rd_en (raw_rd_en),
        .tx         (raw_tx),
        .busy       (raw_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Running scoreboard on the ASCII instance: pops, underflows, frame starts (aborts included).
    int pops = 0, frames = 0, underflow = 0, skip = 0;
    always @(negedge clk) begin
        if (fifo_rd_en) pops++;
        if (fifo_rd_en && fifo_empty) underflow++;
        if (rst) skip = 0;
        else if (skip > 0) skip--;
        else if (tx == 1'b0) begin
            frames++;
            skip = 10 * DIV - 1;
        end
    end

    logic rec_tx [NREC];
    logic rec_rd [NREC];
    logic rec_bz [NREC];
    logic sel = 1'b0;

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec_tx[i] = sel ? raw_tx    : tx;
            rec_rd[i] = sel ? raw_rd_en : fifo_rd_en;
            rec_bz[i] = sel ? raw_busy  : busy;
        end
    endtask

    task automatic push(input logic [2:0] w);
        mem[wptr[3:0]] = w;
        wptr++;
    endtask

    task automatic raw_push(input logic [2:0] w);
        raw_mem[raw_wptr[3:0]] = w;
        raw_wptr++;
    endtask

    function automatic logic smp(input int i);
        if (i < 0 || i >= NREC) return 1'b0;
        return rec_tx[i];
    endfunction

    function automatic int find_start(input int from, input int n);
        for (int i = from; i < n; i++) begin
            if (rec_tx[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = smp(s + DIV * (k + 1) + DIV / 2);
        return d;
    endfunction

    function automatic int count_ones(input int n, input int which);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if (which == 0 && rec_rd[i] == 1'b1) c++;
            if (which == 1 && rec_bz[i] == 1'b1) c++;
            if (which == 2 && rec_tx[i] == 1'b0) c++;
        end
        return c;
    endfunction

    initial begin
        int p, s, s2, s3, first_bz, last_bz;

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_rd_en", fifo_rd_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        record(2000);
        check("empty_pops", count_ones(2000, 0), 0);
        check("empty_tx_low", count_ones(2000, 2), 0);

        push(3'b101);
        record(1000);
        check("single_pops", count_ones(1000, 0), 1);
        p = -1;
        first_bz = -1;
        last_bz = -1;
        for (int i = 0; i < 1000; i++) begin
            if (rec_rd[i] && p < 0) p = i;
            if (rec_bz[i]) begin
                if (first_bz < 0) first_bz = i;
                last_bz = i;
            end
        end
        s = find_start(0, 1000);
        check("single_start_after_pop", s, p + 1);
        check("single_byte", decode(s), 8'h35);
        check("single_start_bit", smp(s + DIV / 2), 1'b0);
        check("single_stop_bit", smp(s + 9 * DIV + DIV / 2), 1'b1);
        check("single_busy_len", count_ones(1000, 1), 431);
        check("single_busy_first", first_bz, p);
        check("single_busy_last", last_bz, s + 10 * DIV - 1);

        push(3'd0);
        push(3'd7);
        push(3'd2);
        record(1400);
        check("burst_pops", count_ones(1400, 0), 3);
        s = find_start(0, 1400);
        s2 = find_start(s + 10 * DIV, 1400);
        s3 = find_start(s2 + 10 * DIV, 1400);
        check("burst_byte0", decode(s), 8'h30);
        check("burst_byte1", decode(s2), 8'h37);
        check("burst_byte2", decode(s3), 8'h32);
        check("burst_gap_high", smp(s + 10 * DIV), 1'b1);
        check("burst_start2", s2, s + 10 * DIV + 1);
        check("burst_start3", s3, s2 + 10 * DIV + 1);

        sel = 1'b1;
        raw_push(3'b110);
        record(500);
        s = find_start(0, 500);
        check("raw_byte", decode(s), 8'h06);
        check("raw_pops", count_ones(500, 0), 1);
        sel = 1'b0;

        push(3'b101);
        p = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                p = i;
                break;
            end
        end
        check("abort_pop_seen", (p >= 0), 1'b1);
        repeat (200) @(negedge clk);
        check("abort_tx_before", tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_tx_async", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        record(600);
        check("abort_no_pop", count_ones(600, 0), 0);
        check("abort_tx_idle", count_ones(600, 2), 0);

        check("sb_underflow", underflow, 0);
        check("sb_pops_vs_frames", pops, frames);
        check("sb_total_pops", pops, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 3: width of the FIFO word consumed.
REQ-002 Parameter CLK_HZ, default 5_000_000: frequency of clk in Hz.
REQ-003 Parameter BAUD, default 115200: serial bit rate.
REQ-004 Parameter ASCII_EN, default 1: 1 = transmit '0'+word (0x30 offset); 0 = transmit the word zero-extended to 8 bits.
REQ-005 clk  input  1  single clock; all logic in this domain.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 fifo_data  input  DATA_BITS  head word of the upstream FIFO; valid whenever fifo_empty=0 (first-word fall-through).
REQ-008 fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 fifo_rd_en  output  1  one-cycle pop strobe to the FIFO rd_en.
REQ-010 tx  output  1  UART serial line; idle high.
REQ-011 busy  output  1  high from the pop cycle until the stop bit completes.

Function
REQ-012 DIV = CLK_HZ/BAUD (integer floor), SHALL be >= 2; default 43 clocks per bit.
REQ-013 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit exactly DIV clocks.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE with fifo_empty=0: assert fifo_rd_en for exactly one clock; in that same cycle capture the encoded fifo_data into an 8-bit shift register; next state START.
REQ-016 IDLE with fifo_empty=1: fifo_rd_en=0, tx=1, busy=0; remain in IDLE.
REQ-017 START: tx=0 for DIV clocks -> DATA with bit index 0.
REQ-018 DATA: tx=shift[0] for DIV clocks, shift right, index+1; after index 7 completes -> STOP.
REQ-019 STOP: tx=1 for DIV clocks -> IDLE; the frame ends on that clock.
REQ-020 Back-to-back: if the FIFO is non-empty at return to IDLE, the next pop occurs on the first IDLE clock; the inter-frame gap is exactly 1 clock of idle-high.
REQ-021 fifo_rd_en SHALL never assert while fifo_empty=1 or outside IDLE (no underflow, one pop per frame).
REQ-022 Encoding: ASCII_EN=1 -> byte = 8'h30 + zero-extended word (8-bit add, wraps modulo 256); ASCII_EN=0 -> zero-extend.
REQ-023 tx and fifo_rd_en SHALL be registered outputs (glitch-free).
REQ-024 Baud counter restarts at 0 on every state entry; no fractional-rate accumulation.

Reset
REQ-025 While rst=1: state=IDLE, tx=1, fifo_rd_en=0, busy=0, counters and shift register cleared.
REQ-026 Reset mid-frame aborts the frame; tx returns high asynchronously; the already-popped word is discarded, not retransmitted.
REQ-027 After rst deasserts, the first pop SHALL occur no earlier than the first clock edge following deassertion.

Structure
REQ-028 Package fifo_uart_pkg holds the state enum (tx_state_t) and a constant function computing DIV from CLK_HZ and BAUD.
REQ-029 One sub-module, baud_gen: counter with a restart input, emitting a one-clock tick every DIV clocks.
REQ-030 The block sits downstream of fifo_sync2 in the FIFO demo top: fifo_data<-data_out, fifo_empty<-empty, fifo_rd_en->rd_en; tx drives a GPIO pin.

Verification
REQ-031 Single word: push 3'b101, ASCII_EN=1 -> one pop; tx frame carries 0x35 ('5') LSB first; frame length 430 clocks; busy high for 431 clocks.
REQ-032 Empty FIFO held 2000 clocks -> fifo_rd_en never asserts, tx constantly 1.
REQ-033 Burst: FIFO holds 0,7,2 -> three pops, 0x30,0x37,0x32 in order, exactly 1 idle clock between frames.
REQ-034 ASCII_EN=0, word 3'b110 -> data bits 0,1,1,0,0,0,0,0 on tx.
REQ-035 rst pulsed 200 clocks into a frame -> tx high within the same cycle, busy=0; after release with FIFO empty, no further pop.
REQ-036 Scoreboard throughout: pop count equals completed-plus-aborted frame count; no pop while fifo_empty=1.
